// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] NULL_INSTR = 32'h0000_0000;
  localparam int          PC_STEP    = 4;
  // Instructions are word aligned; the two low PC bits are forced to zero.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection for the fetch sequencer: rst > redirect > advance > hold.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              advance,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  localparam logic [ADDR_W-1:0] PC_MASK = ALIGN_MASK[ADDR_W-1:0];

  always_comb begin
    pc_next = pc;
    if (rst) begin
      pc_next = ADDR_W'(RESET_PC) & PC_MASK;
    end else if (redirect_valid) begin
      pc_next = redirect_addr & PC_MASK;
    end else if (advance) begin
      pc_next = pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and registered instruction stage between ROM and decode.
// Optional null-word halt is enabled by defining FETCH_NULL_HALT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [1:0]        dbg_state
);

  // Handshake: a word transfers on every cycle with instr_valid && instr_ready;
  // while instr_valid is high and instr_ready low, instr/instr_pc stay frozen.

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [31:0]         r_instr;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic                r_instr_valid;
  logic [CNT_W-1:0]    r_fetch_count;
  logic                w_free;
  logic                w_null;
  logic                w_capture;
  logic                w_clear;

  assign w_free = !r_instr_valid || instr_ready;

`ifdef FETCH_NULL_HALT_EN
  assign w_null = (imem_data == NULL_INSTR);
`else
  assign w_null = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      FETCH, WAIT: begin
        if (redirect_valid) begin
          w_state_next = FETCH;
          w_clear      = 1'b1;
        end else if (w_free && run && w_null) begin
          w_state_next = HALT;
          w_clear      = 1'b1;
        end else if (w_free && run) begin
          w_state_next = FETCH;
          w_capture    = 1'b1;
        end else if (w_free) begin
          w_state_next = FETCH;
          w_clear      = 1'b1;
        end else begin
          w_state_next = WAIT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          w_state_next = FETCH;
          w_clear      = 1'b1;
        end
      end
      default: begin
        w_state_next = FETCH;
        w_clear      = 1'b1;
      end
    endcase
  end

  always_comb begin
`ifdef FETCH_NULL_HALT_EN
    halted = (r_state == HALT);
`else
    halted = 1'b0;
`endif
    dbg_state = r_state;
  end

  fetch_pc_next #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .advance        (w_capture),
    .pc             (r_pc),
    .pc_next        (w_pc_next)
  );

  always_ff @(posedge clk) begin
    r_pc <= w_pc_next;
    if (rst) begin
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (w_capture) begin
        r_instr       <= imem_data;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
      end else if (w_clear) begin
        r_instr_valid <= 1'b0;
      end
      // A word accepted in the same cycle as a flush still counts.
      if (r_instr_valid && instr_ready) begin
        r_fetch_count <= r_fetch_count + 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed plan steps plus randomized traffic
// against a cycle-level reference model. Honours FETCH_NULL_HALT_EN.
module tb_fetch_sequencer;
  import fetch_pkg::*;

`ifdef FETCH_NULL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  dbg_state;

  logic [31:0] rom [0:63];
  assign imem_data = rom[imem_addr[7:2]];

  // reference model state
  logic [7:0]  m_pc;
  logic [7:0]  m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halt;
  logic [15:0] m_cnt;
  logic [39:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(0), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of the sequencer's rules, evaluated with the inputs in force.
  task automatic model_step();
    logic [31:0] word;
    logic        free;
    if (rst) begin
      m_pc = 8'h00; m_ipc = 8'h00; m_instr = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0;
    end else begin
      free = !m_valid || instr_ready;
      if (m_valid && instr_ready) begin
        m_cnt = m_cnt + 16'd1;
        exp_q.push_back({m_ipc, m_instr});
      end
      if (redirect_valid) begin
        m_pc = redirect_addr & 8'hFC;
        m_valid = 1'b0;
        m_halt = 1'b0;
      end else if (!m_halt && free) begin
        if (!run) begin
          m_valid = 1'b0;
        end else begin
          word = rom[m_pc[7:2]];
          if (HALT_EN && word == 32'h0) begin
            m_valid = 1'b0;
            m_halt = 1'b1;
          end else begin
            m_instr = word;
            m_ipc = m_pc;
            m_valid = 1'b1;
            m_pc = m_pc + 8'd4;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("instr", instr, m_instr);
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
  endtask

  task automatic step();
    logic [39:0] e;
    model_step();
    if (!rst && instr_valid === 1'b1 && instr_ready) begin
      chk("hs_q_size", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hs_word", instr, e[31:0]);
        chk("hs_pc", 32'(instr_pc), 32'(e[39:32]));
      end
    end
    if (!rst) chk("hs_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic drive(input logic r, input logic rn, input logic rd,
                       input logic rv, input logic [7:0] ra);
    rst = r; run = rn; instr_ready = rd; redirect_valid = rv; redirect_addr = ra;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h0070_0093;
    rom[1] = 32'h0030_0193;
    rom[2] = 32'hFFF0_0113;

    // reset
    drive(1, 0, 0, 0, 8'h00);
    step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH));

    // streaming with ready held high
    drive(0, 1, 1, 0, 8'h00);
    step();
    chk("s1_instr", instr, 32'h0070_0093);
    chk("s1_pc", 32'(instr_pc), 32'h00);
    step();
    chk("s2_instr", instr, 32'h0030_0193);
    chk("s2_pc", 32'(instr_pc), 32'h04);
    step();
    chk("s3_instr", instr, 32'hFFF0_0113);
    chk("s3_pc", 32'(instr_pc), 32'h08);
    step();
    chk("s4_count", 32'(fetch_count), 32'd3);
`ifdef FETCH_NULL_HALT_EN
    chk("null_halted", 32'(halted), 32'd1);
    chk("null_valid", 32'(instr_valid), 32'd0);
    chk("null_addr", 32'(imem_addr), 32'h0C);
    step();
    chk("halt_hold_addr", 32'(imem_addr), 32'h0C);
    chk("halt_hold", 32'(halted), 32'd1);
`else
    chk("null_instr", instr, 32'h0);
    chk("null_pc", 32'(instr_pc), 32'h0C);
    chk("null_valid", 32'(instr_valid), 32'd1);
    chk("null_halted", 32'(halted), 32'd0);
    step();
`endif
    drive(0, 1, 1, 1, 8'h00);
    step();
    chk("unhalt_halted", 32'(halted), 32'd0);
    chk("unhalt_valid", 32'(instr_valid), 32'd0);
    drive(0, 1, 1, 0, 8'h00);
    step();
    chk("unhalt_instr", instr, 32'h0070_0093);

    // backpressure
    drive(1, 0, 0, 0, 8'h00);
    step();
    drive(0, 1, 0, 0, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_instr", instr, 32'h0070_0093);
      chk("bp_addr", 32'(imem_addr), 32'h04);
      chk("bp_state", 32'(dbg_state), 32'(WAIT));
    end
    drive(0, 1, 1, 0, 8'h00);
    step();
    chk("bp_release", instr, 32'h0030_0193);
    chk("bp_release_v", 32'(instr_valid), 32'd1);

    // redirect to a misaligned target while pc 04 is presented
    drive(0, 1, 1, 1, 8'h0B);
    step();
    chk("rd_valid", 32'(instr_valid), 32'd0);
    chk("rd_addr", 32'(imem_addr), 32'h08);
    chk("rd_count", 32'(fetch_count), 32'd2);
    drive(0, 1, 0, 0, 8'h00);
    step();
    chk("rd_instr", instr, 32'hFFF0_0113);
    chk("rd_pc", 32'(instr_pc), 32'h08);

    // reset while stalled
    step();
    chk("wait_state", 32'(dbg_state), 32'(WAIT));
    drive(1, 1, 0, 0, 8'h00);
    step();
    chk("rw_valid", 32'(instr_valid), 32'd0);
    chk("rw_instr", instr, 32'h0);
    chk("rw_pc", 32'(instr_pc), 32'h0);
    chk("rw_addr", 32'(imem_addr), 32'h00);
    chk("rw_count", 32'(fetch_count), 32'd0);
    chk("rw_state", 32'(dbg_state), 32'(FETCH));

    // PC wrap with a fully populated ROM
    for (int i = 0; i < 64; i++) rom[i] = $urandom | 32'h1;
    drive(0, 1, 1, 1, 8'hFC);
    step();
    chk("wrap_fc", 32'(imem_addr), 32'hFC);
    drive(0, 1, 1, 0, 8'h00);
    step();
    chk("wrap_pc", 32'(instr_pc), 32'hFC);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    chk("wrap_instr", instr, rom[63]);

    // randomized traffic with sparse null words
    for (int i = 0; i < 64; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) == 0,
            8'($urandom_range(0, 255)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
